// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: memory_unit widths and func codes shared by the arbiter slice.
// Func encodings must track memory_unit's GET_CONTENTS/SET_CONTENTS/GET_FREE.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 64;
    localparam int FUNC_W     = 2;

    typedef logic [FUNC_W-1:0] func_t;

    localparam func_t GET_CONTENTS = 2'd0;
    localparam func_t SET_CONTENTS = 2'd1;
    localparam func_t GET_FREE     = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: client command/ack pairs, shared response and memory_unit port.
// slave = arbiter view, master = client/memory environment view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);

    logic              c0_req;
    func_t             c0_func;
    logic [ADDR_W-1:0] c0_addr;
    logic [DATA_W-1:0] c0_wdata;
    logic              c0_ack;

    logic              c1_req;
    func_t             c1_func;
    logic [ADDR_W-1:0] c1_addr;
    logic [DATA_W-1:0] c1_wdata;
    logic              c1_ack;

    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              err;

    logic              mem_execute;
    func_t             mem_func;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic              mem_ready;

    modport slave (
        input  c0_req, c0_func, c0_addr, c0_wdata,
        input  c1_req, c1_func, c1_addr, c1_wdata,
        input  mem_rdata, mem_raddr, mem_ready,
        output c0_ack, c1_ack, rsp_data, rsp_addr, err,
        output mem_execute, mem_func, mem_addr, mem_wdata
    );

    modport master (
        output c0_req, c0_func, c0_addr, c0_wdata,
        output c1_req, c1_func, c1_addr, c1_wdata,
        output mem_rdata, mem_raddr, mem_ready,
        input  c0_ack, c1_ack, rsp_data, rsp_addr, err,
        input  mem_execute, mem_func, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: 2-way round-robin pick; on a tie the client not granted last time wins.
module mem_arb_rr (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       vld_o,
    output logic       gnt_o
);

    assign vld_o = |req_i;

    always_comb begin
        gnt_o = 1'b0;
        unique case (1'b1)
            (req_i == 2'b11): gnt_o = ~last_i;
            (req_i == 2'b10): gnt_o = 1'b1;
            default:          gnt_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client round-robin front end for memory_unit, one command in flight.
// Define MEM_ARB_TIMEOUT_EN for the WAIT watchdog with sticky err.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = MEM_ADDR_W,
    parameter int DATA_W         = MEM_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    func_t             func_q, func_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              pick_vld;
    logic              pick;
    logic              timeout;

    mem_arb_rr u_rr (
        .req_i  ({bus.c1_req, bus.c0_req}),
        .last_i (last_q),
        .vld_o  (pick_vld),
        .gnt_o  (pick)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == S_ISSUE) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT && !bus.mem_ready) begin
            if (timeout) err_d = 1'b1;
            else         cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign timeout = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        func_d  = func_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        raddr_d = raddr_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.mem_ready && pick_vld) begin
                    gnt_d   = pick;
                    func_d  = pick ? bus.c1_func  : bus.c0_func;
                    addr_d  = pick ? bus.c1_addr  : bus.c0_addr;
                    wdata_d = pick ? bus.c1_wdata : bus.c0_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.mem_ready) begin
                    rdata_d = bus.mem_rdata;
                    raddr_d = bus.mem_raddr;
                    state_d = S_DONE;
                end else if (timeout) begin
                    // give up but still ack so the client unblocks
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_d  = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            func_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            func_q  <= func_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            raddr_q <= raddr_d;
        end
    end

    assign bus.mem_execute = (state_q == S_ISSUE);
    assign bus.mem_func    = func_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.c0_ack      = (state_q == S_DONE) && !gnt_q;
    assign bus.c1_ack      = (state_q == S_DONE) && gnt_q;
    assign bus.rsp_data    = rdata_q;
    assign bus.rsp_addr    = raddr_q;

endmodule
